// File: rtl/mt_err_pkg.sv
// Shared constants for the MT error-register file: error bit positions and the
// mask of bits the drive/formatter logic actually implements.
package mt_err_pkg;

  localparam int unsigned MT_ERR_ILF    = 0;
  localparam int unsigned MT_ERR_ILR    = 1;
  localparam int unsigned MT_ERR_RMR    = 2;
  localparam int unsigned MT_ERR_PAR    = 3;
  localparam int unsigned MT_ERR_FMTE   = 4;
  localparam int unsigned MT_ERR_DPAR   = 5;
  localparam int unsigned MT_ERR_INCVPE = 6;
  localparam int unsigned MT_ERR_PEFLRC = 7;
  localparam int unsigned MT_ERR_NSG    = 8;
  localparam int unsigned MT_ERR_FCE    = 9;
  localparam int unsigned MT_ERR_CSIMT  = 10;
  localparam int unsigned MT_ERR_NEF    = 11;
  localparam int unsigned MT_ERR_DTE    = 12;
  localparam int unsigned MT_ERR_OPI    = 13;
  localparam int unsigned MT_ERR_UNS    = 14;
  localparam int unsigned MT_ERR_CORCRC = 15;

  localparam logic [15:0] MT_ERR_IMPL_MASK = 16'h7A3F;

  // Unit index width; never narrower than one bit so single-unit builds still have a port.
  function automatic int unsigned mt_err_unit_w(int unsigned num_units);
    return (num_units > 1) ? $clog2(num_units) : 1;
  endfunction

endpackage

// File: rtl/mt_err_unit.sv
// State for one drive unit: sticky error register, first-error capture,
// saturating set-event counter and zero-to-nonzero attention pulse.
module mt_err_unit
  import mt_err_pkg::*;
#(
  parameter int unsigned          WIDTH     = 16,
  parameter int unsigned          CNT_W     = 8,
  parameter logic [WIDTH-1:0]     IMPL_MASK = WIDTH'(MT_ERR_IMPL_MASK)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             set_hit_i,
  input  logic [WIDTH-1:0] set_mask_i,
  input  logic [WIDTH-1:0] clr_mask_i,
  input  logic             dclr_hit_i,
  output logic [WIDTH-1:0] er_o,
  output logic [WIDTH-1:0] first_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             atten_o
);

  logic [WIDTH-1:0] er_q, er_d;
  logic [WIDTH-1:0] first_q, first_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             atten_q, atten_d;

  always_comb begin
    // Set is applied after clear so a new error is never lost to a same-cycle clear.
    er_d = ((er_q & ~clr_mask_i) | (set_hit_i ? set_mask_i : '0)) & IMPL_MASK;

    first_d = first_q;
    if ((er_q == '0) && set_hit_i) begin
      first_d = set_mask_i;
    end else if (er_d == '0) begin
      first_d = '0;
    end

    cnt_d = cnt_q;
    if (dclr_hit_i) begin
      cnt_d = set_hit_i ? CNT_W'(1) : '0;
    end else if (set_hit_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    atten_d = (er_q == '0) && (er_d != '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      er_q    <= '0;
      first_q <= '0;
      cnt_q   <= '0;
      atten_q <= 1'b0;
    end else begin
      er_q    <= er_d;
      first_q <= first_d;
      cnt_q   <= cnt_d;
      atten_q <= atten_d;
    end
  end

  assign er_o    = er_q;
  assign first_o = first_q;
  assign cnt_o   = cnt_q;
  assign atten_o = atten_q;

endmodule

// File: rtl/mt_err_file.sv
// Per-drive MT error-register file: decodes set/drive-clear/W1C traffic to each
// unit and presents a registered read port for the register-bus decoder.
module mt_err_file
  import mt_err_pkg::*;
#(
  parameter int unsigned      WIDTH     = 16,
  parameter int unsigned      NUM_UNITS = 8,
  parameter logic [WIDTH-1:0] IMPL_MASK = WIDTH'(MT_ERR_IMPL_MASK),
  parameter int unsigned      CNT_W     = 8,
  localparam int unsigned     UW        = mt_err_unit_w(NUM_UNITS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 init,
  input  logic                 set_valid,
  input  logic [UW-1:0]        set_unit,
  input  logic [WIDTH-1:0]     set_bits,
  input  logic                 dclr_valid,
  input  logic [UW-1:0]        dclr_unit,
  input  logic                 wr_valid,
  input  logic [UW-1:0]        wr_unit,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic [UW-1:0]        rd_unit,
  output logic [WIDTH-1:0]     rd_data,
  output logic [WIDTH-1:0]     rd_first,
  output logic [CNT_W-1:0]     rd_count,
  output logic [NUM_UNITS-1:0] err_any,
  output logic [NUM_UNITS-1:0] atten
);

  logic             clr_all;
  logic [WIDTH-1:0] set_mask;
  logic             set_any;

  logic [WIDTH-1:0] er    [NUM_UNITS];
  logic [WIDTH-1:0] first [NUM_UNITS];
  logic [CNT_W-1:0] cnt   [NUM_UNITS];

  assign clr_all  = rst | init;
  assign set_mask = set_bits & IMPL_MASK;
  // A set touching only unimplemented bits is a non-event.
  assign set_any  = set_valid && (set_mask != '0);

  for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
    logic             set_hit;
    logic             dclr_hit;
    logic             wr_hit;
    logic [WIDTH-1:0] clr_mask;

    assign set_hit  = set_any && (set_unit == UW'(u));
    assign dclr_hit = dclr_valid && (dclr_unit == UW'(u));
    assign wr_hit   = wr_valid && (wr_unit == UW'(u));
    assign clr_mask = (dclr_hit ? '1 : '0) | (wr_hit ? wr_data : '0);

    mt_err_unit #(
      .WIDTH     (WIDTH),
      .CNT_W     (CNT_W),
      .IMPL_MASK (IMPL_MASK)
    ) u_unit (
      .clk_i      (clk),
      .rst_i      (clr_all),
      .set_hit_i  (set_hit),
      .set_mask_i (set_mask),
      .clr_mask_i (clr_mask),
      .dclr_hit_i (dclr_hit),
      .er_o       (er[u]),
      .first_o    (first[u]),
      .cnt_o      (cnt[u]),
      .atten_o    (atten[u])
    );

    assign err_any[u] = |er[u];
  end

  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic [WIDTH-1:0] rd_first_q, rd_first_d;
  logic [CNT_W-1:0] rd_count_q, rd_count_d;

  // Indices with no matching unit fall through to zero.
  always_comb begin
    rd_data_d  = '0;
    rd_first_d = '0;
    rd_count_d = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (rd_unit == UW'(u)) begin
        rd_data_d  = er[u];
        rd_first_d = first[u];
        rd_count_d = cnt[u];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr_all) begin
      rd_data_q  <= '0;
      rd_first_q <= '0;
      rd_count_q <= '0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_first_q <= rd_first_d;
      rd_count_q <= rd_count_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_first = rd_first_q;
  assign rd_count = rd_count_q;

endmodule
